// File: rtl/aes_addroundkey_stage.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule (one step per accepted beat).
// Optional define AES_ARK_SKID_EN replaces the single output register with a 2-entry skid buffer.
module aes_addroundkey_stage #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_out,
    output logic         last_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
    localparam logic [7:0] RCON_INIT  = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 via an addition chain: 254 = 240 + 12 + 2; zero maps to zero naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a12;
        logic [7:0] t;
        a2  = gf_mul(a, a);
        a3  = gf_mul(a2, a);
        a12 = gf_mul(a3, a3);
        a12 = gf_mul(a12, a12);
        t   = gf_mul(a12, a3);
        for (int i = 0; i < 4; i++)
            t = gf_mul(t, t);
        return gf_mul(gf_mul(t, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic         key_ok;
    logic [127:0] rk_cur;
    logic [127:0] key_saved;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         accept;
    logic         last_round;
    logic [127:0] ark;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t_word;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_cur[31:0];
    assign w1 = rk_cur[63:32];
    assign w2 = rk_cur[95:64];
    assign w3 = rk_cur[127:96];

    // RotWord moves byte0 (bits 31:24) to the least significant byte position
    assign t_word = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign last_round = (round == LAST_ROUND);
    assign accept     = in_valid & in_ready;
    assign ark        = state_in ^ rk_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ok    <= 1'b0;
            rk_cur    <= '0;
            key_saved <= '0;
            rcon      <= RCON_INIT;
            round     <= 4'd0;
        end else if (key_load) begin
            key_ok    <= 1'b1;
            key_saved <= key_in;
            rk_cur    <= key_in;
            rcon      <= RCON_INIT;
            round     <= 4'd0;
        end else if (accept) begin
            if (last_round) begin
                rk_cur <= key_saved;
                rcon   <= RCON_INIT;
                round  <= 4'd0;
            end else begin
                rk_cur <= {n3, n2, n1, n0};
                rcon   <= xtime(rcon);
                round  <= round + 4'd1;
            end
        end
    end

`ifdef AES_ARK_SKID_EN

    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
    } beat_t;

    beat_t      slot0, slot1, slot0_nxt, slot1_nxt, new_beat;
    logic [1:0] count, count_nxt;
    logic       pop;

    assign in_ready = key_ok & ~key_load & (count != 2'd2);
    assign pop      = (count != 2'd0) & out_ready;
    assign new_beat = {ark, round, last_round};

    // slot0 is always the head; a new beat lands behind whatever survives this cycle's pop
    always_comb begin
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        if (pop)
            slot0_nxt = slot1;
        if (accept) begin
            if ((count == 2'd0) || ((count == 2'd1) && pop))
                slot0_nxt = new_beat;
            else
                slot1_nxt = new_beat;
        end
        count_nxt = count + {1'b0, accept} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
            count <= count_nxt;
        end
    end

    assign out_valid = (count != 2'd0);
    assign state_out = slot0.st;
    assign round_out = slot0.rnd;
    assign last_out  = slot0.last;

`else

    assign in_ready = key_ok & ~key_load & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            state_out <= '0;
            round_out <= 4'd0;
            last_out  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            state_out <= ark;
            round_out <= round;
            last_out  <= last_round;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_aes_addroundkey_stage.sv
// Scoreboard bench for aes_addroundkey_stage using the FIPS-197 A.1 key expansion table.
// Expectations are pushed at accept time and popped by an independent output monitor.
module tb_aes_addroundkey_stage;

    localparam logic [127:0] KEY_A1  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] KEY_ALT = 128'h0c0d0e0f_08090a0b_04050607_00010203;
`ifdef AES_ARK_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   rnd;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   round_out;
    logic         last_out;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t expQ[$];
    int    modelKey = 0;
    logic [3:0] modelRound = 4'd0;

    aes_addroundkey_stage dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .round_out (round_out),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    // FIPS-197 A.1 round keys, written {w(4r+3), w(4r+2), w(4r+1), w(4r)}
    function automatic logic [127:0] roundKey(input int keyId, input logic [3:0] r);
        if (keyId != 0)
            return KEY_ALT;
        case (r)
            4'd0:    return 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
            4'd1:    return 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
            4'd2:    return 128'h7359f67f_5935807a_7a96b943_f2c295f2;
            4'd3:    return 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
            4'd4:    return 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
            4'd5:    return 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
            4'd6:    return 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
            4'd7:    return 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
            4'd8:    return 128'h7f8d292f_312bf560_b58dbad2_ead27321;
            4'd9:    return 128'h575c006e_28d12941_19fadc21_ac7766f3;
            default: return 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [132:0] act, input logic [132:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input logic [127:0] s);
        beat_t b;
        b.st   = s ^ roundKey(modelKey, modelRound);
        b.rnd  = modelRound;
        b.last = (modelRound == 4'd10);
        expQ.push_back(b);
        modelRound = (modelRound == 4'd10) ? 4'd0 : modelRound + 4'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic keyLoad(input logic [127:0] k, input int keyId);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load   = 1'b0;
        modelKey   = keyId;
        modelRound = 4'd0;
    endtask

    // Offers one beat and waits (bounded) until the stage takes it
    task automatic applyStimulus(input logic [127:0] s);
        int  waitCycles;
        bit  done;
        waitCycles = 0;
        done       = 1'b0;
        in_valid   = 1'b1;
        state_in   = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                pushExpected(s);
                done = 1'b1;
            end else if (++waitCycles > 50) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL accept_timeout: in_ready stuck at %0d, required 1", in_ready);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every handshake on the output pops one expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_beat: got %h/%0d with no beat outstanding, required none",
                         state_out, round_out);
            end else begin
                beat_t b;
                b = expQ.pop_front();
                checkOutput("beat", {state_out, round_out, last_out}, b);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] pat [0:3];
        logic [127:0] held;
        bit           haveHeld;
        int           accepts;

        rst = 1'b1; key_load = 1'b0; key_in = '0;
        in_valid = 1'b0; state_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_state_out", state_out, 128'h0);
        checkOutput("reset_round_out", round_out, 4'd0);
        checkOutput("reset_last_out", last_out, 1'b0);
        tick();

        // No key loaded yet: the stage must refuse beats
        in_valid = 1'b1;
        state_in = 128'h12345678_9abcdef0_0fedcba9_87654321;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("nokey_in_ready", in_ready, 1'b0);
            checkOutput("nokey_out_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // Full FIPS A.1 schedule with zero states, then one more beat to see the wrap
        keyLoad(KEY_A1, 0);
        for (int r = 0; r < 12; r++)
            applyStimulus(128'h0);
        tick();

        // Backpressure: count accepts and watch the head stay stable
        pat[0] = 128'h11111111_22222222_33333333_44444444;
        pat[1] = 128'ha5a5a5a5_5a5a5a5a_f0f0f0f0_0f0f0f0f;
        pat[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        pat[3] = 128'h0;
        accepts  = 0;
        haveHeld = 1'b0;
        held     = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state_in  = pat[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!haveHeld) begin
                    held     = state_out;
                    haveHeld = 1'b1;
                end else begin
                    checkOutput("stall_stable", state_out, held);
                end
            end
            if (in_ready) begin
                pushExpected(state_in);
                accepts++;
            end
            tick();
            state_in = pat[accepts];
        end
        in_valid = 1'b0;
        checkOutput("stall_accepts", accepts, STALL_ACCEPTS);
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("stall_drained", expQ.size(), 0);

        // Reload the key while a round-5 beat is parked at the output
        while (modelRound != 4'd5)
            applyStimulus(128'h00112233_44556677_8899aabb_ccddeeff ^ {124'h0, modelRound});
        tick();
        out_ready = 1'b0;
        applyStimulus(128'hfeedface_0badf00d_13579bdf_2468ace0);
        keyLoad(KEY_ALT, 1);
        @(negedge clk);
        checkOutput("reload_pending_held", out_valid, 1'b1);
        tick();
        out_ready = 1'b1;
        applyStimulus(128'h00112233_44556677_8899aabb_ccddeeff);
        repeat (2) tick();

        // Asynchronous reset in the middle of a block
        keyLoad(KEY_A1, 0);
        for (int r = 0; r < 4; r++)
            applyStimulus(128'h01010101_02020202_03030303_04040404 << r);
        #1 rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("async_rst_out_valid", out_valid, 1'b0);
        checkOutput("async_rst_state_out", state_out, 128'h0);
        tick();
        rst = 1'b0;
        modelRound = 4'd0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1'b0);
        tick();
        keyLoad(KEY_A1, 0);
        applyStimulus(128'h3243f6a8_885a308d_313198a2_e0370734);
        applyStimulus(128'hffffffff_00000000_ffffffff_00000000);
        repeat (3) tick();
        checkOutput("final_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
